dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Control stage directly upstream of the 2-way data-cache SRAM (16 sets, 256-bit lines, 25-bit tag entry: bit24 valid, bit23 dirty, bits22:0 tag).
- Accepts 32-bit word loads/stores from the CPU MEM stage and drives the SRAM index, tag, data and write strobes.
- On a miss it runs write-back/refill transactions to a 256-bit main-memory port and stalls the CPU until the access can replay as a hit.
- Policy is write-back, write-allocate.

Parameters:
- NSET_BITS, 4, index width (16 sets)
- LINE_BITS, 256, line width
- OFS_BITS, 5, byte offset within a line

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  CPU access request
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address: tag [31:9], index [8:5], word [4:2]
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold its request and inputs
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fetched line
- mem_ack_i  in  1  one-cycle completion pulse
- sram_enable_o  out  1  SRAM enable
- sram_write_o  out  1  SRAM write strobe
- sram_index_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_tag_i  in  25  hit-way tag, or LRU victim tag on a miss
- sram_data_i  in  256  hit-way line, or victim line
- sram_hit_i  in  1  hit indication

Behaviour:
- Reset, asynchronous: state = IDLE; all outputs and internal registers are 0. Asserting reset mid-transaction drops mem_enable_o in the same instant; memory must discard any in-flight request.
- sram_index_o = cpu_addr_i[8:5] at all times. sram_enable_o = cpu_req_i or (state != IDLE).
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
- IDLE, request with hit:
  - Load: cpu_data_o = sram_data_i word cpu_addr_i[4:2], combinational. Zero extra cycles.
  - Store: sram_write_o = 1 in the same cycle. sram_data_o = sram_data_i with word [4:2] replaced by cpu_data_i. sram_tag_o = {1, 1, cpu_addr_i[31:9]}.
  - cpu_stall_o = 0.
- IDLE, request with miss: cpu_stall_o = 1 combinationally; next state = MISS.
- MISS:
  - Latch victim = {sram_tag_i, sram_data_i}.
  - If victim bit24 and bit23 are both set, go to WRITEBACK; otherwise go to READMISS.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag[22:0], index, 5'b0}; mem_data_o = latched victim line.
  - On mem_ack_i, go to READMISS.
- READMISS:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu_addr_i[31:5], 5'b0}.
  - On mem_ack_i, in that same cycle: sram_write_o = 1, sram_data_o = mem_data_i, sram_tag_o = {1, 0, cpu_addr_i[31:9]}. Next state = READMISSOK.
- READMISSOK: sram_write_o = 0; cpu_stall_o stays 1; next state = IDLE. The request then replays in IDLE as a hit. A store therefore completes one cycle after re-entering IDLE and marks the line dirty.
- mem_enable_o is a level, held from state entry through the ack cycle inclusive. A back-to-back WRITEBACK→READMISS is treated by memory as a new request in the cycle after the ack.
- mem_ack_i outside WRITEBACK/READMISS is ignored. Ack in the first cycle of a state is legal.
- cpu_stall_o = 1 whenever state != IDLE. The CPU holds address, data and write stable while stalled.
- cpu_req_i = 0 in IDLE: no SRAM write, stall 0, cpu_data_o = 0.
- Latency: clean miss = 3 cycles + memory latency; dirty miss = 3 cycles + 2 × memory latency. Replay hit adds 0 cycles.

Test Plan:
- Reset during READMISS with mem_enable_o high → mem_enable_o, cpu_stall_o and sram_write_o all 0 immediately; state IDLE.
- Load 0x0000_0044, cold miss, victim tag 0:
  - MISS → READMISS with mem_addr_o = 0x0000_0040, mem_write_o = 0.
  - Ack after 10 cycles with line word1 = 0xDEAD_BEEF → SRAM written with tag {1, 0, 0}.
  - cpu_data_o = 0xDEAD_BEEF on replay; stall lasts 13 cycles.
- Store 0x1234_5678 to 0x0000_0048 on a hit line → single cycle, no stall. sram_data_o word2 = 0x1234_5678, other words unchanged; sram_tag_o bits 24:23 = 2'b11.
- Load 0x0000_2040 (same set 2), victim tag = {1, 1, 23'h0}:
  - WRITEBACK with mem_addr_o = 0x0000_0040, mem_write_o = 1, mem_data_o = victim line.
  - After ack, READMISS with mem_addr_o = 0x0000_2040.
- Store miss to 0x0000_0104 → refill, then replay writes word1 with dirty = 1. Subsequent load returns the store data.
- mem_ack_i pulsed while in IDLE → no state change, no SRAM write.

Source files
------------

// File: rtl/dcache_controller.sv
// Write-back, write-allocate control stage for a 2-way data-cache SRAM.
// Replays CPU word accesses as hits after any write-back/refill line traffic to main memory.
module dcache_controller #(
    parameter int unsigned NSET_BITS = 4,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned OFS_BITS  = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cpu_req_i,
    input  logic                               cpu_write_i,
    input  logic [31:0]                        cpu_addr_i,
    input  logic [31:0]                        cpu_data_i,
    output logic [31:0]                        cpu_data_o,
    output logic                               cpu_stall_o,
    output logic                               mem_enable_o,
    output logic                               mem_write_o,
    output logic [31:0]                        mem_addr_o,
    output logic [LINE_BITS-1:0]               mem_data_o,
    input  logic [LINE_BITS-1:0]               mem_data_i,
    input  logic                               mem_ack_i,
    output logic                               sram_enable_o,
    output logic                               sram_write_o,
    output logic [NSET_BITS-1:0]               sram_index_o,
    output logic [33-NSET_BITS-OFS_BITS:0]     sram_tag_o,
    output logic [LINE_BITS-1:0]               sram_data_o,
    input  logic [33-NSET_BITS-OFS_BITS:0]     sram_tag_i,
    input  logic [LINE_BITS-1:0]               sram_data_i,
    input  logic                               sram_hit_i
);

    localparam int unsigned TAG_BITS  = 32 - NSET_BITS - OFS_BITS;
    localparam int unsigned WORD_BITS = OFS_BITS - 2;
    localparam int unsigned BOFS_BITS = OFS_BITS + 3;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [TAG_BITS-1:0]    victim_tag;
    logic [LINE_BITS-1:0]   victim_data;

    logic [TAG_BITS-1:0]    req_tag;
    logic [NSET_BITS-1:0]   req_index;
    logic [WORD_BITS-1:0]   req_word;
    logic [BOFS_BITS-1:0]   word_ofs;
    logic                   unused_addr_lsb;

    assign req_tag         = cpu_addr_i[31 -: TAG_BITS];
    assign req_index       = cpu_addr_i[OFS_BITS +: NSET_BITS];
    assign req_word        = cpu_addr_i[OFS_BITS-1:2];
    assign word_ofs        = {req_word, 5'b0};
    assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};
    assign sram_index_o    = req_index;

    // State register plus victim capture while the SRAM presents the LRU way.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            victim_tag  <= '0;
            victim_data <= '0;
        end else begin
            state <= next_state;
            if (state == MISS) begin
                victim_tag  <= sram_tag_i[TAG_BITS-1:0];
                victim_data <= sram_data_i;
            end
        end
    end

    always_comb begin
        next_state    = state;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        sram_enable_o = cpu_req_i || (state != IDLE);
        sram_write_o  = 1'b0;
        sram_tag_o    = '0;
        sram_data_o   = '0;

        case (state)
            IDLE: begin
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o               = 1'b1;
                            sram_data_o                = sram_data_i;
                            sram_data_o[word_ofs +: 32] = cpu_data_i;
                            sram_tag_o                 = {2'b11, req_tag};
                        end else begin
                            cpu_data_o = sram_data_i[word_ofs +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        next_state  = MISS;
                    end
                end
            end
            MISS: begin
                cpu_stall_o = 1'b1;
                // Only a valid and dirty victim needs to go back to memory.
                if (sram_tag_i[TAG_BITS+1] && sram_tag_i[TAG_BITS]) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = READMISS;
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag, req_index, OFS_BITS'(0)};
                mem_data_o   = victim_data;
                if (mem_ack_i) begin
                    next_state = READMISS;
                end
            end
            READMISS: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_addr_i[31:OFS_BITS], OFS_BITS'(0)};
                if (mem_ack_i) begin
                    sram_write_o = 1'b1;
                    sram_data_o  = mem_data_i;
                    sram_tag_o   = {2'b10, req_tag};
                    next_state   = READMISSOK;
                end
            end
            READMISSOK: begin
                cpu_stall_o = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Reset silences every strobe immediately, including an in-flight memory request.
        if (rst_i) begin
            cpu_data_o    = '0;
            cpu_stall_o   = 1'b0;
            mem_enable_o  = 1'b0;
            mem_write_o   = 1'b0;
            mem_addr_o    = '0;
            mem_data_o    = '0;
            sram_enable_o = 1'b0;
            sram_write_o  = 1'b0;
            sram_tag_o    = '0;
            sram_data_o   = '0;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a direct-mapped SRAM model and a hand-driven memory port.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dcache_controller;

    logic         clk;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [3:0]   sram_index_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    int errors;
    int checks;

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_c;
    logic [255:0] exp_line;

    logic [24:0]  tag_mem  [16];
    logic [255:0] data_mem [16];

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_index_o  (sram_index_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .sram_hit_i    (sram_hit_i)
    );

    always #5 clk = ~clk;

    // Direct-mapped stand-in for the SRAM: the resident line doubles as the victim.
    assign sram_tag_i  = tag_mem[sram_index_o];
    assign sram_data_i = data_mem[sram_index_o];
    assign sram_hit_i  = tag_mem[sram_index_o][24] &&
                         (tag_mem[sram_index_o][22:0] == cpu_addr_i[31:9]);

    always @(posedge clk) begin
        if (sram_enable_o && sram_write_o) begin
            tag_mem[sram_index_o]  <= sram_tag_o;
            data_mem[sram_index_o] <= sram_data_o;
        end
    end

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", cpu_stall_o); end
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_mem_enable: got %b expected 0", mem_enable_o); end
        checks++; if (sram_write_o !== 1'b0) begin errors++; $display("FAIL reset_sram_write: got %b expected 0", sram_write_o); end
        checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data_o); end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (mem_enable_o !== 1'b1) begin errors++; $display("FAIL midrst_in_readmiss: got %b expected 1", mem_enable_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL midrst_mem_enable: got %b expected 0", mem_enable_o); end
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", cpu_stall_o); end
        checks++; if (sram_write_o !== 1'b0) begin errors++; $display("FAIL midrst_sram_write: got %b expected 0", sram_write_o); end
        @(posedge clk); #1;
        rst_i = 1'b0; cpu_req_i = 1'b0;
        @(negedge clk);
        checks++; if (sram_enable_o !== 1'b0) begin errors++; $display("FAIL midrst_idle_enable: got %b expected 0", sram_enable_o); end
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL midrst_idle_stall: got %b expected 0", cpu_stall_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        int  stall_cnt = 0;
        int  ph = 0;
        bit  done = 1'b0;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0044;
        mem_data_i = line_a;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_ack_i = mem_enable_o && (ph == 9);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (cpu_stall_o !== 1'b1) begin errors++; $display("FAIL lmiss_stall_now: got %b expected 1", cpu_stall_o); end
            end
            if (mem_enable_o && ph == 0) begin
                checks++; if (mem_addr_o !== 32'h0000_0040) begin errors++; $display("FAIL lmiss_addr: got %h expected 00000040", mem_addr_o); end
                checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL lmiss_mem_write: got %b expected 0", mem_write_o); end
            end
            if (mem_ack_i) begin
                checks++; if (sram_write_o !== 1'b1) begin errors++; $display("FAIL lmiss_fill_we: got %b expected 1", sram_write_o); end
                checks++; if (sram_tag_o !== 25'h100_0000) begin errors++; $display("FAIL lmiss_fill_tag: got %h expected 1000000", sram_tag_o); end
                checks++; if (sram_data_o !== line_a) begin errors++; $display("FAIL lmiss_fill_data: got %h expected %h", sram_data_o, line_a); end
            end
            if (mem_enable_o) ph = mem_ack_i ? 0 : ph + 1;
            if (cpu_stall_o) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                checks++; if (cpu_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lmiss_replay_data: got %h expected deadbeef", cpu_data_o); end
            end
            @(posedge clk); #1;
        end
        mem_ack_i = 1'b0; cpu_req_i = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL lmiss_timeout: got stalled expected replay"); end
        checks++; if (stall_cnt != 13) begin errors++; $display("FAIL lmiss_stall_cycles: got %0d expected 13", stall_cnt); end
    endtask

    task automatic test_store_hit();
        exp_line = line_a;
        exp_line[95:64] = 32'h1234_5678;
        cpu_req_i = 1'b1; cpu_write_i = 1'b1; cpu_addr_i = 32'h0000_0048; cpu_data_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL shit_stall: got %b expected 0", cpu_stall_o); end
        checks++; if (sram_write_o !== 1'b1) begin errors++; $display("FAIL shit_we: got %b expected 1", sram_write_o); end
        checks++; if (sram_data_o !== exp_line) begin errors++; $display("FAIL shit_data: got %h expected %h", sram_data_o, exp_line); end
        checks++; if (sram_tag_o !== 25'h180_0000) begin errors++; $display("FAIL shit_tag: got %h expected 1800000", sram_tag_o); end
        @(posedge clk); #1;
        cpu_write_i = 1'b0;
        @(negedge clk);
        checks++; if (cpu_data_o !== 32'h1234_5678) begin errors++; $display("FAIL shit_readback: got %h expected 12345678", cpu_data_o); end
        checks++; if (sram_write_o !== 1'b0) begin errors++; $display("FAIL shit_load_we: got %b expected 0", sram_write_o); end
        @(posedge clk); #1;
        cpu_addr_i = 32'h0000_0044;
        @(negedge clk);
        checks++; if (cpu_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL shit_neighbour: got %h expected deadbeef", cpu_data_o); end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  stall_cnt = 0;
        int  ph = 0;
        int  np = 0;
        bit  done = 1'b0;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_2040;
        mem_data_i = line_b;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_ack_i = mem_enable_o && (ph == 2);
            @(negedge clk);
            if (mem_enable_o && ph == 0) begin
                if (np == 0) begin
                    checks++; if (mem_write_o !== 1'b1) begin errors++; $display("FAIL b2b_wb_write: got %b expected 1", mem_write_o); end
                    checks++; if (mem_addr_o !== 32'h0000_0040) begin errors++; $display("FAIL b2b_wb_addr: got %h expected 00000040", mem_addr_o); end
                    checks++; if (mem_data_o !== exp_line) begin errors++; $display("FAIL b2b_wb_data: got %h expected %h", mem_data_o, exp_line); end
                end else begin
                    checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL b2b_rm_write: got %b expected 0", mem_write_o); end
                    checks++; if (mem_addr_o !== 32'h0000_2040) begin errors++; $display("FAIL b2b_rm_addr: got %h expected 00002040", mem_addr_o); end
                end
            end
            if (mem_ack_i && np == 1) begin
                checks++; if (sram_tag_o !== 25'h100_0010) begin errors++; $display("FAIL b2b_fill_tag: got %h expected 1000010", sram_tag_o); end
            end
            if (mem_enable_o) begin
                if (mem_ack_i) begin ph = 0; np++; end
                else ph++;
            end
            if (cpu_stall_o) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                checks++; if (cpu_data_o !== 32'hB000_0000) begin errors++; $display("FAIL b2b_replay_data: got %h expected b0000000", cpu_data_o); end
            end
            @(posedge clk); #1;
        end
        mem_ack_i = 1'b0; cpu_req_i = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: got stalled expected replay"); end
        checks++; if (np != 2) begin errors++; $display("FAIL b2b_mem_txns: got %0d expected 2", np); end
        checks++; if (stall_cnt != 9) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 9", stall_cnt); end
    endtask

    task automatic test_store_miss();
        int  stall_cnt = 0;
        bit  done = 1'b0;
        exp_line = line_c;
        exp_line[63:32] = 32'h5555_AAAA;
        cpu_req_i = 1'b1; cpu_write_i = 1'b1; cpu_addr_i = 32'h0000_0104; cpu_data_i = 32'h5555_AAAA;
        mem_data_i = line_c;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_ack_i = mem_enable_o;
            @(negedge clk);
            if (mem_enable_o) begin
                checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL smiss_mem_write: got %b expected 0", mem_write_o); end
                checks++; if (mem_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL smiss_addr: got %h expected 00000100", mem_addr_o); end
            end
            if (cpu_stall_o) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                checks++; if (sram_write_o !== 1'b1) begin errors++; $display("FAIL smiss_replay_we: got %b expected 1", sram_write_o); end
                checks++; if (sram_tag_o !== 25'h180_0000) begin errors++; $display("FAIL smiss_replay_tag: got %h expected 1800000", sram_tag_o); end
                checks++; if (sram_data_o !== exp_line) begin errors++; $display("FAIL smiss_replay_data: got %h expected %h", sram_data_o, exp_line); end
            end
            @(posedge clk); #1;
        end
        mem_ack_i = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL smiss_timeout: got stalled expected replay"); end
        checks++; if (stall_cnt != 4) begin errors++; $display("FAIL smiss_stall_cycles: got %0d expected 4", stall_cnt); end
        cpu_write_i = 1'b0;
        @(negedge clk);
        checks++; if (cpu_data_o !== 32'h5555_AAAA) begin errors++; $display("FAIL smiss_load_back: got %h expected 5555aaaa", cpu_data_o); end
        @(posedge clk); #1;
        cpu_addr_i = 32'h0000_0108;
        @(negedge clk);
        checks++; if (cpu_data_o !== 32'hC000_0002) begin errors++; $display("FAIL smiss_load_word2: got %h expected c0000002", cpu_data_o); end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic test_ack_idle();
        cpu_req_i = 1'b0; mem_ack_i = 1'b1;
        @(negedge clk);
        checks++; if (sram_write_o !== 1'b0) begin errors++; $display("FAIL ackidle_we: got %b expected 0", sram_write_o); end
        checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL ackidle_cpu_data: got %h expected 0", cpu_data_o); end
        checks++; if (sram_enable_o !== 1'b0) begin errors++; $display("FAIL ackidle_enable: got %b expected 0", sram_enable_o); end
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (sram_enable_o !== 1'b0) begin errors++; $display("FAIL ackidle_state: got %b expected 0", sram_enable_o); end
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL ackidle_mem_enable: got %b expected 0", mem_enable_o); end
        @(posedge clk); #1;
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0104;
        @(negedge clk);
        checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL ackidle_hit_stall: got %b expected 0", cpu_stall_o); end
        checks++; if (cpu_data_o !== 32'h5555_AAAA) begin errors++; $display("FAIL ackidle_hit_data: got %h expected 5555aaaa", cpu_data_o); end
        @(posedge clk); #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        errors = 0;
        checks = 0;
        rst_i = 1'b1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            line_a[32*k +: 32] = 32'hA000_0000 + 32'(k);
            line_b[32*k +: 32] = 32'hB000_0000 + 32'(k);
            line_c[32*k +: 32] = 32'hC000_0000 + 32'(k);
        end
        line_a[63:32] = 32'hDEAD_BEEF;
        exp_line = '0;

        test_reset();
        test_reset_mid();
        test_load_miss();
        test_store_hit();
        test_back_to_back();
        test_store_miss();
        test_ack_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
